// File: rtl/led_display_pattern_gen_param.sv
// Test-pattern row source for a double-scan HUB75 panel: one registered row per
// valid/ready transfer, with row address, frame-done strobe and selectable patterns.
module led_display_pattern_gen_param #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int SCAN_FRAMES    = 64,
  parameter int BAR_W          = 8,
  parameter int SIMULATION     = 0
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [3:0]                            mode_in,
  output logic [6*NUM_COL_PIXELS-1:0]           row_out,
  output logic                                  row_valid_out,
  input  logic                                  row_ready_in,
  output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]   row_address_out,
  output logic                                  frame_done_out
);

  localparam int HALF     = NUM_ROW_PIXELS / 2;
  localparam int AW       = $clog2(HALF);
  localparam int N        = NUM_COL_PIXELS;
  localparam int CW       = $clog2(NUM_COL_PIXELS);
  localparam int SCAN_EFF = (SIMULATION != 0) ? 1 : SCAN_FRAMES;
  localparam int FW       = $clog2(SCAN_EFF + 1);

  localparam logic [AW-1:0] ADDR_LAST  = AW'(HALF - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(N - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCAN_EFF - 1);

  localparam logic [3:0] MODE_RED   = 4'd1;
  localparam logic [3:0] MODE_GREEN = 4'd2;
  localparam logic [3:0] MODE_BLUE  = 4'd3;
  localparam logic [3:0] MODE_RG    = 4'd4;
  localparam logic [3:0] MODE_GB    = 4'd5;
  localparam logic [3:0] MODE_RB    = 4'd6;
  localparam logic [3:0] MODE_WHITE = 4'd7;
  localparam logic [3:0] MODE_SCAN  = 4'd8;
  localparam logic [3:0] MODE_CHECK = 4'd9;
  localparam logic [3:0] MODE_BARS  = 4'd10;

  // Top and bottom rows differ by HALF (even), so they share parity and pattern.
  function automatic logic [6*N-1:0] row_pattern(input logic [3:0]    mode,
                                                 input logic          addr_odd,
                                                 input logic [CW-1:0] col);
    logic [N-1:0] r, g, b;
    r = '0;
    g = '0;
    b = '0;
    for (int c = 0; c < N; c++) begin
      case (mode)
        MODE_RED:   r[c] = 1'b1;
        MODE_GREEN: g[c] = 1'b1;
        MODE_BLUE:  b[c] = 1'b1;
        MODE_RG:    begin r[c] = 1'b1; g[c] = 1'b1; end
        MODE_GB:    begin g[c] = 1'b1; b[c] = 1'b1; end
        MODE_RB:    begin r[c] = 1'b1; b[c] = 1'b1; end
        MODE_WHITE: begin r[c] = 1'b1; g[c] = 1'b1; b[c] = 1'b1; end
        MODE_SCAN:
          if (col == CW'(c)) begin
            r[c] = 1'b1; g[c] = 1'b1; b[c] = 1'b1;
          end
        MODE_CHECK:
          if (addr_odd == c[0]) begin
            r[c] = 1'b1; g[c] = 1'b1; b[c] = 1'b1;
          end
        MODE_BARS:
          case ((c / BAR_W) % 3)
            0:       r[c] = 1'b1;
            1:       g[c] = 1'b1;
            default: b[c] = 1'b1;
          endcase
        default: ;
      endcase
    end
    return {r, g, b, r, g, b};
  endfunction

  logic [3:0]    mode_q;
  logic [AW-1:0] addr_p0;
  logic [CW-1:0] scan_col;
  logic [FW-1:0] frame_cnt;
  logic [6*N-1:0] row_p0;
  logic          vld_p0;
  logic          fd_p0;

  logic          last_row;
  logic [AW-1:0] addr_nxt;
  logic [CW-1:0] col_nxt;
  logic [FW-1:0] frame_nxt;

  always_comb begin
    last_row  = (addr_p0 == ADDR_LAST);
    addr_nxt  = last_row ? '0 : addr_p0 + AW'(1);
    col_nxt   = scan_col;
    frame_nxt = frame_cnt;
    if (last_row) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nxt = '0;
        col_nxt   = (scan_col == COL_LAST) ? '0 : scan_col + CW'(1);
      end else begin
        frame_nxt = frame_cnt + FW'(1);
      end
    end
  end

  // Output stage p0: the row is loaded for the address it will carry next.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mode_q    <= '0;
      addr_p0   <= '0;
      scan_col  <= '0;
      frame_cnt <= '0;
      row_p0    <= '0;
      vld_p0    <= 1'b0;
      fd_p0     <= 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q    <= mode_in;
      addr_p0   <= '0;
      scan_col  <= '0;
      frame_cnt <= '0;
      vld_p0    <= 1'b0;
      fd_p0     <= 1'b0;
    end else if (!vld_p0) begin
      row_p0 <= row_pattern(mode_q, addr_p0[0], scan_col);
      vld_p0 <= 1'b1;
      fd_p0  <= 1'b0;
    end else if (row_ready_in) begin
      addr_p0   <= addr_nxt;
      scan_col  <= col_nxt;
      frame_cnt <= frame_nxt;
      row_p0    <= row_pattern(mode_q, addr_nxt[0], col_nxt);
      fd_p0     <= last_row;
    end else begin
      fd_p0 <= 1'b0;
    end
  end

  assign row_out         = row_p0;
  assign row_valid_out   = vld_p0;
  assign row_address_out = addr_p0;
  assign frame_done_out  = fd_p0;

endmodule

// File: tb/tb_led_display_pattern_gen_param.sv
// Scoreboard bench for led_display_pattern_gen_param: expected rows are queued by
// the stimulus and checked by a negedge monitor whenever a row is presented.
module tb_led_display_pattern_gen_param;

  localparam int NR       = 32;
  localparam int NC       = 64;
  localparam int HALF     = NR / 2;
  localparam int AW       = $clog2(HALF);
  localparam int SF       = 64;
  localparam int BW       = 8;
  localparam int SIM      = 1;
  localparam int SCAN_EFF = (SIM != 0) ? 1 : SF;

  logic              clk = 1'b0;
  logic              reset_in;
  logic [3:0]        mode_in;
  logic [6*NC-1:0]   row_out;
  logic              row_valid_out;
  logic              row_ready_in;
  logic [AW-1:0]     row_address_out;
  logic              frame_done_out;

  always #5 clk = ~clk;

  led_display_pattern_gen_param #(
    .NUM_ROW_PIXELS(NR),
    .NUM_COL_PIXELS(NC),
    .SCAN_FRAMES   (SF),
    .BAR_W         (BW),
    .SIMULATION    (SIM)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .mode_in        (mode_in),
    .row_out        (row_out),
    .row_valid_out  (row_valid_out),
    .row_ready_in   (row_ready_in),
    .row_address_out(row_address_out),
    .frame_done_out (frame_done_out)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [6*NC-1:0] row;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cur_mode;
  int   cur_idx;
  logic exp_fd = 1'b0;

  // Reference: the row for transfer number idx since the mode was entered.
  function automatic logic [6*NC-1:0] model_row(input int mode, input int idx);
    logic [6*NC-1:0] v;
    logic [2:0]      p;
    int addr, frame, scan, r;
    v     = '0;
    addr  = idx % HALF;
    frame = idx / HALF;
    scan  = (frame / SCAN_EFF) % NC;
    for (int h = 0; h < 2; h++) begin
      r = addr + h * HALF;
      for (int c = 0; c < NC; c++) begin
        case (mode)
          1:  p = 3'b100;
          2:  p = 3'b010;
          3:  p = 3'b001;
          4:  p = 3'b110;
          5:  p = 3'b011;
          6:  p = 3'b101;
          7:  p = 3'b111;
          8:  p = (c == scan) ? 3'b111 : 3'b000;
          9:  p = (((r + c) % 2) == 0) ? 3'b111 : 3'b000;
          10: case ((c / BW) % 3)
                0:       p = 3'b100;
                1:       p = 3'b010;
                default: p = 3'b001;
              endcase
          default: p = 3'b000;
        endcase
        v[(5 - 3*h)*NC + c] = p[2];
        v[(4 - 3*h)*NC + c] = p[1];
        v[(3 - 3*h)*NC + c] = p[0];
      end
    end
    return v;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [6*NC-1:0] act, input logic [6*NC-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare presented rows with the queue head; pop on transfer.
  always @(negedge clk) begin
    vectors++;
    if (frame_done_out !== exp_fd) begin
      miscompares++;
      $display("FAIL frame_done: got %0b expected %0b", frame_done_out, exp_fd);
    end
    exp_fd = 1'b0;
    if (row_valid_out === 1'b1) begin
      if (q.size() > 0) begin
        vectors++;
        if (row_address_out !== q[0].addr || row_out !== q[0].row) begin
          miscompares++;
          $display("FAIL row mode %0d: got addr %0d row %h expected addr %0d row %h",
                   cur_mode, row_address_out, row_out, q[0].addr, q[0].row);
        end
        if (row_ready_in) begin
          exp_fd = (int'(q[0].addr) == HALF - 1);
          void'(q.pop_front());
        end
      end else if (row_ready_in) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_transfer: got addr %0d expected no transfer", row_address_out);
      end
    end
  end

  task automatic push_rows(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = AW'(cur_idx % HALF);
      e.row  = model_row(cur_mode, cur_idx);
      q.push_back(e);
      cur_idx++;
    end
  endtask

  // Called and returns at posedge+1; leaves ready low with the next row presented.
  task automatic drive(input bit rnd);
    int budget;
    budget = q.size() * 6 + 50;
    while (q.size() > 0 && budget > 0) begin
      row_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      budget--;
    end
    row_ready_in = 1'b0;
    if (q.size() > 0) begin
      miscompares++;
      vectors++;
      $display("FAIL drain_timeout: got %0d rows pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic change_mode(input int m);
    mode_in      = 4'(m);
    row_ready_in = 1'b0;
    q.delete();
    cur_mode = m;
    cur_idx  = 0;
    @(posedge clk);
    #1;
    chk_int("bubble_valid", int'(row_valid_out), 0);
    chk_int("bubble_addr", int'(row_address_out), 0);
  endtask

  initial begin
    int modes[10] = '{1, 2, 3, 4, 5, 6, 7, 10, 9, 11};
    reset_in     = 1'b1;
    row_ready_in = 1'b0;
    mode_in      = 4'd0;
    cur_mode     = 0;
    cur_idx      = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_valid", int'(row_valid_out), 0);
    chk_int("reset_addr", int'(row_address_out), 0);
    chk_int("reset_fd", int'(frame_done_out), 0);
    chk_row("reset_row", row_out, '0);

    reset_in = 1'b0;
    @(posedge clk);
    #1;
    chk_int("first_valid", int'(row_valid_out), 1);
    push_rows(40);
    drive(1'b0);

    foreach (modes[i]) begin
      change_mode(modes[i]);
      push_rows(20);
      drive(1'b1);
    end

    // Scan: full column wrap, then stall mid-frame and reset.
    change_mode(8);
    push_rows(65 * HALF);
    drive(1'b0);
    push_rows(HALF + 9);
    drive(1'b1);
    chk_int("stall_valid", int'(row_valid_out), 1);
    chk_int("stall_addr", int'(row_address_out), 9);
    reset_in = 1'b1;
    @(posedge clk);
    #1;
    chk_int("midreset_valid", int'(row_valid_out), 0);
    chk_int("midreset_addr", int'(row_address_out), 0);
    chk_row("midreset_row", row_out, '0);
    reset_in = 1'b0;
    q.delete();
    cur_idx = 0;
    @(posedge clk);
    #1;
    chk_int("postreset_bubble", int'(row_valid_out), 0);
    push_rows(HALF);
    drive(1'b0);

    // Mode change while a row is stalled.
    change_mode(1);
    push_rows(5);
    drive(1'b1);
    chk_int("stall5_valid", int'(row_valid_out), 1);
    chk_int("stall5_addr", int'(row_address_out), 5);
    change_mode(2);
    push_rows(HALF + 3);
    drive(1'b1);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
